// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a single 8-bit ALU.
// One operation is accepted in IDLE. It executes in EXEC and is then held
// in RESP until the consumer takes it.
//   clk, rst_n              clock, synchronous active-low reset
//   reqN_valid/ctrl/x/y     operation request from requester N (N = 0,1)
//   reqN_ready              requester N's operation is accepted this cycle
//   rsp_valid/id/out/carry  result, the requester that owns it, carry flag
//   rsp_ready               consumer accepts the result
//   done_cnt0/1             saturating count of results delivered per requester
module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [3:0] req0_ctrl,
  input  logic [3:0] req1_ctrl,
  input  logic [7:0] req0_x,
  input  logic [7:0] req0_y,
  input  logic [7:0] req1_x,
  input  logic [7:0] req1_y,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_out,
  output logic       rsp_carry,
  input  logic       rsp_ready,
  output logic [7:0] done_cnt0,
  output logic [7:0] done_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic       last_grant_q;
  logic [3:0] op_ctrl_q;
  logic [7:0] op_x_q, op_y_q;
  logic       op_id_q;
  logic [7:0] rsp_out_q;
  logic       rsp_carry_q, rsp_id_q;
  logic [7:0] cnt0_q, cnt1_q;

  logic       grant_any, grant_id;
  logic [8:0] xs, ys, pre;
  logic [2:0] sh;
  logic       carry_d;

  // Next state, grant and handshake outputs.
  always_comb begin
    state_d   = state_q;
    grant_any = 1'b0;
    grant_id  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by rst_n so no ready is visible while reset is held.
        if (rst_n) begin
          if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = ~last_grant_q;
          end else if (req0_valid) begin
            grant_any = 1'b1;
          end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
          end
        end
        if (grant_any) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req0_ready = grant_any && !grant_id;
    req1_ready = grant_any && grant_id;
  end

  // ALU on the latched operands; both operands sign-extended to 9 bits.
  always_comb begin
    xs = {op_x_q[7], op_x_q};
    ys = {op_y_q[7], op_y_q};
    sh = op_x_q[2:0];
    pre = '0;
    case (op_ctrl_q)
      4'b0000: pre = xs + ys;
      4'b0001: pre = xs - ys;
      4'b0010: pre = xs & ys;
      4'b0011: pre = xs | ys;
      4'b0100: pre = ~xs;
      4'b0101: pre = xs ^ ys;
      4'b0110: pre = ~(xs | ys);
      4'b0111: pre = ys << sh;
      4'b1000: pre = $signed(ys) >>> sh;
      4'b1001: pre = {1'b0, op_x_q[7], op_x_q[7:1]};
      4'b1010: pre = {1'b0, op_x_q[6:0], op_x_q[7]};
      4'b1011: pre = {1'b0, op_x_q[0], op_x_q[7:1]};
      4'b1100: pre = (op_x_q == op_y_q) ? 9'd1 : 9'd0;
      default: pre = '0;
    endcase
    carry_d = (op_ctrl_q == 4'b0000 || op_ctrl_q == 4'b0001) ? pre[8] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_ctrl_q    <= '0;
      op_x_q       <= '0;
      op_y_q       <= '0;
      op_id_q      <= 1'b0;
      rsp_out_q    <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q <= state_d;
      if (grant_any) begin
        last_grant_q <= grant_id;
        op_id_q      <= grant_id;
        op_ctrl_q    <= grant_id ? req1_ctrl : req0_ctrl;
        op_x_q       <= grant_id ? req1_x    : req0_x;
        op_y_q       <= grant_id ? req1_y    : req0_y;
      end
      if (state_q == EXEC) begin
        rsp_out_q   <= pre[7:0];
        rsp_carry_q <= carry_d;
        rsp_id_q    <= op_id_q;
      end
      if (state_q == RESP && rsp_ready) begin
        if (!rsp_id_q && cnt0_q != 8'hFF) cnt0_q <= cnt0_q + 8'd1;
        if (rsp_id_q && cnt1_q != 8'hFF) cnt1_q <= cnt1_q + 8'd1;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_carry = rsp_carry_q;
  assign done_cnt0 = cnt0_q;
  assign done_cnt1 = cnt1_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 req0_valid, req1_valid  input  1 each  requester n has an operation pending.
REQ-004 req0_ctrl, req1_ctrl  input  4 each  opcode from requester n.
REQ-005 req0_x, req0_y, req1_x, req1_y  input  8 each  signed operands from requester n.
REQ-006 req0_ready, req1_ready  output  1 each  requester n's operation is accepted this cycle.
REQ-007 rsp_valid  output  1  result is available.
REQ-008 rsp_id  output  1  index of the requester that owns the result.
REQ-009 rsp_out  output  8  result value.
REQ-010 rsp_carry  output  1  carry flag.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 done_cnt0, done_cnt1  output  8 each  saturating count of results delivered per requester.

Function
REQ-013 The block SHALL use a 3-state FSM: IDLE, EXEC, RESP.
REQ-014 IDLE: if any reqN_valid, the block SHALL grant exactly one requester, assert its reqN_ready combinationally, latch ctrl/x/y/id, and go to EXEC.
REQ-015 reqN_ready SHALL be 0 in EXEC and RESP; the block accepts at most one operation per cycle.
REQ-016 Arbitration SHALL be round-robin. If both valid, grant the requester not in last_grant. If one valid, grant it. last_grant updates only on a grant.
REQ-017 EXEC: the block SHALL compute the op from the latched operands into a 9-bit pre-result, register out=pre[7:0], carry and id into the rsp registers, and go to RESP.
REQ-018 Op table (x, y sign-extended to 9 bits):
- 0000 x+y
- 0001 x-y
- 0010 x&y
- 0011 x|y
- 0100 ~x
- 0101 x^y
- 0110 ~(x|y)
- 0111 y<<<x[2:0]
- 1000 y>>>x[2:0] (arithmetic)
- 1001 {x[7],x[7:1]}
- 1010 {x[6:0],x[7]}
- 1011 {x[0],x[7:1]}
- 1100 (x==y)?1:0
- 1101-1111 0
REQ-019 rsp_carry SHALL be pre[8] for ctrl 0000/0001 and 0 otherwise.
REQ-020 RESP: rsp_valid SHALL be 1. rsp_id/out/carry SHALL be stable until the handshake. When rsp_valid && rsp_ready, go to IDLE and increment done_cnt[rsp_id], saturating at 8'hFF.
REQ-021 Latency: acceptance at edge T means rsp_valid is high in the cycle after edge T+1. With rsp_ready held high, throughput is one op per 3 cycles.
REQ-022 A requester dropping valid outside IDLE SHALL NOT affect an in-flight operation. Operands SHALL NOT be re-sampled after the grant.
REQ-023 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-024 With rst_n=0 at a rising edge, the block SHALL go to IDLE and clear rsp_valid, rsp_id, rsp_out, rsp_carry, done_cnt0, done_cnt1 and the operand registers. last_grant SHALL be set to 1, so requester 0 wins the first tie.
REQ-025 reqN_ready SHALL be 0 while rst_n=0.
REQ-026 Reset in EXEC or RESP SHALL abandon the operation: no response and no count increment.

Verification
REQ-027 After reset, both valid: req0 (0000,x=7F,y=01), req1 (0001,x=05,y=03); rsp_ready=1 -> first rsp id=0 out=80 carry=0, then id=1 out=02; grants alternate 0,1,0,1 while both stay valid.
REQ-028 req0 (0000,x=80,y=80) -> out=00 carry=1. req0 (0010,x=F0,y=3C) -> out=30 carry=0.
REQ-029 Shifts/rotates: (0111,x=02,y=81) -> 04; (1000,x=02,y=81) -> E0; (1010,x=81) -> 03; (1011,x=81) -> C0; (1100,x=y=5A) -> 01; (1110) -> 00.
REQ-030 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp fields stable, both readys 0, done_cnt unchanged. Then rsp_ready=1 -> one increment and return to IDLE.
REQ-031 Reset asserted in EXEC -> next cycle rsp_valid=0, counters 0, and a tie grants req0.
REQ-032 Deliver 260 req1 results -> done_cnt1=FF and done_cnt0=00.
